// File: rtl/capture_pkg.sv
// Shared types and widths for the video capture sequencer and its output buffer.
package capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_CAPTURE  = 2'd2,
    ST_DRAIN    = 2'd3
  } state_e;

  localparam int unsigned OUT_DATA_W = 32;
  localparam int unsigned SIDEBAND_W = 2;

  // Buffer entry is {tuser, tlast, pixel}.
  function automatic int unsigned entry_width(input int unsigned pix_w);
    return pix_w + SIDEBAND_W;
  endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous FIFO with registered full/valid flags; a read frees a slot for a
// write in the same cycle.
module capture_fifo #(
  parameter int unsigned DATA_W = 26,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              valid
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              valid_q, valid_d;
  logic              wr_fire_c, rd_fire_c;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_fire_c = rd_en & valid_q;
    wr_fire_c = wr_en & (~full_q | rd_fire_c);
    if (wr_fire_c) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_fire_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    cnt_d   = cnt_q + CW'(wr_fire_c) - CW'(rd_fire_c);
    full_d  = (cnt_d == CW'(DEPTH));
    valid_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      valid_q  <= valid_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign valid   = valid_q;

endmodule

// File: rtl/capture_seq_ctrl.sv
// Frame capture sequencer: locks onto SOF, counts frame geometry, tags line/frame
// boundaries and streams pixels out over AXI-Stream through a small buffer.
module capture_seq_ctrl
  import capture_pkg::*;
#(
  parameter int unsigned PIX_W      = 24,
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cfg_enable,
  input  logic                  cfg_single,
  input  logic                  cfg_clear,
  input  logic [CNT_W-1:0]      cfg_hsize,
  input  logic [CNT_W-1:0]      cfg_vsize,
  input  logic                  vid_valid,
  input  logic                  vid_sof,
  input  logic [PIX_W-1:0]      vid_data,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [OUT_DATA_W-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overflow,
  output logic                  sof_err,
  output logic [15:0]           frame_count
);

  localparam int unsigned ENTRY_W = entry_width(PIX_W);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0]   hsize_q, hsize_d, vsize_q, vsize_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               overflow_q, overflow_d;
  logic               sof_err_q, sof_err_d;
  logic [15:0]        frame_count_q, frame_count_d;

  logic               fifo_full, fifo_valid;
  logic [ENTRY_W-1:0] rd_entry;
  logic [ENTRY_W-1:0] wr_entry_c;
  logic [CNT_W-1:0]   eff_h_c, eff_v_c, cur_h_c, cur_v_c, cur_x_c, cur_y_c;
  logic               start_c, pix_c, last_x_c, last_y_c, rd_fire_c, drop_c;
  logic               drain_done_c;

  // Pixel decode: the SOF pixel uses freshly latched geometry at position (0,0).
  always_comb begin
    eff_h_c      = (cfg_hsize == '0) ? CNT_W'(1) : cfg_hsize;
    eff_v_c      = (cfg_vsize == '0) ? CNT_W'(1) : cfg_vsize;
    start_c      = (state_q == ST_WAIT_SOF) & cfg_enable & vid_valid & vid_sof;
    pix_c        = start_c | ((state_q == ST_CAPTURE) & vid_valid);
    cur_h_c      = start_c ? eff_h_c : hsize_q;
    cur_v_c      = start_c ? eff_v_c : vsize_q;
    cur_x_c      = start_c ? '0 : x_q;
    cur_y_c      = start_c ? '0 : y_q;
    last_x_c     = (cur_x_c == cur_h_c - CNT_W'(1));
    last_y_c     = (cur_y_c == cur_v_c - CNT_W'(1));
    rd_fire_c    = fifo_valid & m_axis_tready;
    drop_c       = pix_c & fifo_full & ~rd_fire_c;
    wr_entry_c   = {start_c, last_x_c, vid_data};
    drain_done_c = (state_q == ST_DRAIN) & ~fifo_valid;
  end

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    hsize_d       = hsize_q;
    vsize_d       = vsize_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_enable) state_d = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        if (!cfg_enable) begin
          state_d = ST_IDLE;
        end else if (start_c) begin
          hsize_d = eff_h_c;
          vsize_d = eff_v_c;
          state_d = (last_x_c && last_y_c) ? ST_DRAIN : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (pix_c && last_x_c && last_y_c) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_done_c) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          state_d       = (cfg_single || !cfg_enable) ? ST_IDLE : ST_WAIT_SOF;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Dropped pixels still advance geometry so tlast/tuser stay aligned.
    if (pix_c) begin
      x_d = last_x_c ? '0 : cur_x_c + CNT_W'(1);
      if (last_x_c) y_d = last_y_c ? '0 : cur_y_c + CNT_W'(1);
    end

    if (cfg_clear) frame_count_d = '0;
    overflow_d = drop_c | (overflow_q & ~cfg_clear);
    sof_err_d  = ((state_q == ST_CAPTURE) & vid_valid & vid_sof) | (sof_err_q & ~cfg_clear);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q       <= ST_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      hsize_q       <= '0;
      vsize_q       <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
      sof_err_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsize_q       <= hsize_d;
      vsize_q       <= vsize_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      overflow_q    <= overflow_d;
      sof_err_q     <= sof_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  capture_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (ACLK),
    .rst     (ARESET),
    .wr_en   (pix_c),
    .wr_data (wr_entry_c),
    .rd_en   (m_axis_tready),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .valid   (fifo_valid)
  );

  assign m_axis_tvalid = fifo_valid;
  assign m_axis_tdata  = OUT_DATA_W'(rd_entry[PIX_W-1:0]);
  assign m_axis_tlast  = rd_entry[PIX_W];
  assign m_axis_tuser  = rd_entry[PIX_W+1];
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign overflow      = overflow_q;
  assign sof_err       = sof_err_q;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_capture_seq_ctrl.sv
// Scoreboard bench for capture_seq_ctrl: a frame-level model predicts beats and
// status; a negedge monitor checks every AXI-Stream handshake and frame_done.
module tb_capture_seq_ctrl;

  localparam int unsigned PIX_W = 24;
  localparam int unsigned CNT_W = 12;
  localparam int DEPTH = 4;

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic              cfg_enable, cfg_single, cfg_clear;
  logic [CNT_W-1:0]  cfg_hsize, cfg_vsize;
  logic              vid_valid, vid_sof;
  logic [PIX_W-1:0]  vid_data;
  logic              m_axis_tvalid, m_axis_tready;
  logic [31:0]       m_axis_tdata;
  logic              m_axis_tlast, m_axis_tuser;
  logic              busy, frame_done, overflow, sof_err;
  logic [15:0]       frame_count;

  always #5 ACLK = ~ACLK;

  capture_seq_ctrl #(.PIX_W(PIX_W), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cfg_enable(cfg_enable), .cfg_single(cfg_single), .cfg_clear(cfg_clear),
    .cfg_hsize(cfg_hsize), .cfg_vsize(cfg_vsize),
    .vid_valid(vid_valid), .vid_sof(vid_sof), .vid_data(vid_data),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .busy(busy), .frame_done(frame_done), .overflow(overflow), .sof_err(sof_err),
    .frame_count(frame_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: expected beats, buffer occupancy, frame progress, sticky status.
  logic [33:0] sb[$];
  int occ, k, hm, vm, exp_fc, frames_total, fd_seen;
  bit in_frame, exp_ovf, exp_serr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    occ = 0; k = 0; in_frame = 0;
    exp_ovf = 0; exp_serr = 0; exp_fc = 0;
    frames_total = 0; fd_seen = 0;
  endtask

  // Drive one cycle of video input and predict its effect at the next edge.
  task automatic step(input logic vv, input logic sof, input logic [PIX_W-1:0] d);
    bit pop;
    logic tu, tl;
    vid_valid = vv; vid_sof = sof; vid_data = d;
    pop = m_axis_tready && (occ > 0);
    if (cfg_clear) begin exp_ovf = 0; exp_serr = 0; exp_fc = 0; end
    if (vv) begin
      if (!in_frame && sof) begin
        in_frame = 1; k = 0;
        hm = (cfg_hsize == '0) ? 1 : int'(cfg_hsize);
        vm = (cfg_vsize == '0) ? 1 : int'(cfg_vsize);
      end else if (in_frame && sof) begin
        exp_serr = 1;
      end
      if (in_frame) begin
        tu = (k == 0);
        tl = ((k % hm) == hm - 1);
        if (occ < DEPTH || pop) begin
          sb.push_back({tu, tl, 32'(d)});
          occ++;
        end else begin
          exp_ovf = 1;
        end
        k++;
        if (k == hm * vm) begin
          in_frame = 0;
          exp_fc = (exp_fc + 1) % 65536;
          frames_total++;
        end
      end
    end
    if (pop) occ--;
    @(posedge ACLK); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((sb.size() != 0 || fd_seen != frames_total) && t < 200) begin
      step(1'b0, 1'b0, '0);
      t++;
    end
    check({name, "_drained"}, 64'(sb.size() == 0 && fd_seen == frames_total), 64'(1));
    idle(2);
  endtask

  task automatic check_status(input string name);
    check({name, "_overflow"}, 64'(overflow), 64'(exp_ovf));
    check({name, "_sof_err"}, 64'(sof_err), 64'(exp_serr));
    check({name, "_frame_count"}, 64'(frame_count), 64'(exp_fc));
  endtask

  task automatic frame_seq(input int n, input int sof_at);
    for (int i = 0; i < n; i++) step(1'b1, (i == 0) || (i == sof_at), PIX_W'(i + 1));
  endtask

  // Monitor: every handshake pops one expected beat; held beats must not change.
  logic [33:0] held, cur;
  bit holding = 0;
  always @(negedge ACLK) begin
    if (ARESET) begin
      holding = 0;
    end else begin
      cur = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (holding && m_axis_tvalid) check("hold_stable", 64'(cur), 64'(held));
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL beat_unexpected: got 0x%0h, expected no beat at %0t", cur, $time);
        end else begin
          check("beat", 64'(cur), 64'(sb.pop_front()));
        end
      end
      holding = m_axis_tvalid && !m_axis_tready;
      held = cur;
      if (frame_done) begin
        fd_seen++;
        check("done_after_drain", 64'(sb.size()), 64'(0));
        check("busy_after_done", 64'(busy), 64'(!(cfg_single || !cfg_enable)));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int h, v, n;
    bit glitch;
    ARESET = 1; cfg_enable = 0; cfg_single = 0; cfg_clear = 0;
    cfg_hsize = '0; cfg_vsize = '0; vid_valid = 0; vid_sof = 0; vid_data = '0;
    m_axis_tready = 1;
    model_reset();
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("rst_tdata", 64'(m_axis_tdata), 64'(0));
    check("rst_tlast", 64'(m_axis_tlast), 64'(0));
    check("rst_tuser", 64'(m_axis_tuser), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    check("rst_flags", 64'({overflow, sof_err}), 64'(0));
    check("rst_frame_count", 64'(frame_count), 64'(0));
    ARESET = 0;

    // Single 4x2 frame; stray pixels before SOF are ignored.
    cfg_hsize = 12'd4; cfg_vsize = 12'd2; cfg_single = 1; cfg_enable = 1;
    step(1'b1, 1'b0, 24'h000055);
    step(1'b1, 1'b0, 24'h000066);
    frame_seq(8, -1);
    wait_drain("single");
    check_status("single");
    cfg_enable = 0;
    idle(2);
    check("idle_after_disable", 64'(busy), 64'(0));

    // Output stalled 10 cycles: the last four pixels overflow.
    cfg_clear = 1; cfg_enable = 1;
    idle(1);
    cfg_clear = 0;
    idle(1);
    m_axis_tready = 0;
    frame_seq(8, -1);
    idle(2);
    m_axis_tready = 1;
    wait_drain("stall");
    check_status("stall");
    cfg_enable = 0;
    idle(2);

    // SOF on pixel 3 flags sof_err; clear on the same cycle loses to the error.
    cfg_enable = 1;
    idle(2);
    for (int i = 0; i < 8; i++) begin
      cfg_clear = (i == 2);
      step(1'b1, (i == 0) || (i == 2), PIX_W'(i + 1));
    end
    cfg_clear = 0;
    wait_drain("sof_err");
    check_status("sof_err");
    cfg_enable = 0;
    idle(2);

    // Continuous mode: two frames, busy stays up in between.
    cfg_single = 0; cfg_enable = 1;
    idle(2);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) step(1'b1, i == 0, PIX_W'($urandom));
      wait_drain("continuous");
      check("busy_between_frames", 64'(busy), 64'(1));
    end
    check_status("continuous");
    cfg_enable = 0;
    idle(2);
    check("idle_after_continuous", 64'(busy), 64'(0));

    // Reset mid-line with two beats buffered, then a clean frame.
    cfg_single = 1; cfg_enable = 1; m_axis_tready = 0;
    idle(2);
    step(1'b1, 1'b1, 24'hAAAAAA);
    step(1'b1, 1'b0, 24'hBBBBBB);
    check("pre_reset_tvalid", 64'(m_axis_tvalid), 64'(1));
    ARESET = 1;
    #1;
    check("reset_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_tdata", 64'(m_axis_tdata), 64'(0));
    check("reset_frame_count", 64'(frame_count), 64'(0));
    model_reset();
    step(1'b0, 1'b0, '0);
    ARESET = 0; m_axis_tready = 1;
    idle(2);
    frame_seq(8, -1);
    wait_drain("post_reset");
    check_status("post_reset");

    // Zero geometry degenerates to a single-pixel frame.
    cfg_hsize = '0; cfg_vsize = '0;
    idle(2);
    step(1'b1, 1'b1, 24'h123456);
    wait_drain("one_pixel");
    check_status("one_pixel");
    cfg_enable = 0;
    idle(2);

    // Randomized frames: gaps, stalls, mid-frame SOF and config changes.
    cfg_clear = 1; cfg_single = 0; cfg_enable = 1;
    idle(1);
    cfg_clear = 0;
    idle(2);
    for (int f = 0; f < 10; f++) begin
      h = $urandom_range(0, 5);
      v = $urandom_range(0, 3);
      cfg_hsize = CNT_W'(h); cfg_vsize = CNT_W'(v);
      n = ((h == 0) ? 1 : h) * ((v == 0) ? 1 : v);
      for (int i = 0; i < n; i++) begin
        while ($urandom_range(0, 3) == 0) begin
          m_axis_tready = 1'($urandom_range(0, 1));
          step(1'b0, 1'b0, '0);
        end
        m_axis_tready = 1'($urandom_range(0, 1));
        if (i > 0 && $urandom_range(0, 7) == 0) cfg_hsize = CNT_W'($urandom_range(0, 7));
        glitch = (i > 0) && ($urandom_range(0, 9) == 0);
        step(1'b1, (i == 0) || glitch, PIX_W'($urandom));
      end
      m_axis_tready = 1;
      wait_drain("random");
      check_status("random");
    end
    cfg_enable = 0;
    idle(3);
    check("final_idle", 64'(busy), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/capture_seq_ctrl.md
CAPTURE_SEQ_CTRL -- requirements
Module: capture_seq_ctrl

Interface
REQ-001 SHALL have parameter PIX_W, default 24, giving the pixel width.
REQ-002 SHALL have parameter CNT_W, default 12, giving the width of the line and frame counters.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, giving the number of output buffer entries (power of 2).
REQ-004 SHALL have port ACLK, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port ARESET, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port cfg_enable, input, 1 bit: run capture while high.
REQ-007 SHALL have port cfg_single, input, 1 bit: capture one frame, then return to IDLE.
REQ-008 SHALL have port cfg_clear, input, 1 bit: a one-cycle pulse that clears the sticky status flags and frame_count.
REQ-009 SHALL have port cfg_hsize, input, CNT_W bits: pixels per line.
REQ-010 SHALL have port cfg_vsize, input, CNT_W bits: lines per frame.
REQ-011 SHALL have port vid_valid, input, 1 bit: pixel strobe; the source has no backpressure.
REQ-012 SHALL have port vid_sof, input, 1 bit: start-of-frame marker, qualified by vid_valid.
REQ-013 SHALL have port vid_data, input, PIX_W bits: pixel value.
REQ-014 SHALL have port m_axis_tvalid, output, 1 bit: AXI-Stream valid.
REQ-015 SHALL have port m_axis_tready, input, 1 bit: AXI-Stream ready.
REQ-016 SHALL have port m_axis_tdata, output, 32 bits: zero-extended pixel.
REQ-017 SHALL have port m_axis_tlast, output, 1 bit: end of line.
REQ-018 SHALL have port m_axis_tuser, output, 1 bit: first pixel of frame.
REQ-019 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-020 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a frame is complete.
REQ-021 SHALL have port overflow, output, 1 bit: sticky flag, pixel dropped.
REQ-022 SHALL have port sof_err, output, 1 bit: sticky flag, vid_sof received mid-frame.
REQ-023 SHALL have port frame_count, output, 16 bits: frames completed; wraps from 0xFFFF to 0.

Function
REQ-024 SHALL implement the states IDLE, WAIT_SOF, CAPTURE and DRAIN.
REQ-025 SHALL move IDLE->WAIT_SOF when cfg_enable=1.
REQ-026 SHALL move WAIT_SOF->CAPTURE on vid_valid&vid_sof; that pixel is the first pixel of the frame. If cfg_enable drops while in WAIT_SOF, the state SHALL return to IDLE.
REQ-027 SHALL latch cfg_hsize and cfg_vsize on the WAIT_SOF->CAPTURE transition; a latched value of 0 SHALL be treated as 1. Configuration changes mid-frame SHALL have no effect.
REQ-028 In CAPTURE, each vid_valid pixel SHALL advance counter x; at x=hsize-1, x SHALL wrap to 0 and y SHALL increment.
REQ-029 The pixel at x=hsize-1 SHALL carry tlast=1; the first pixel of the frame SHALL carry tuser=1.
REQ-030 When the pixel at x=hsize-1 and y=vsize-1 is captured, the state SHALL move CAPTURE->DRAIN.
REQ-031 Pixels SHALL be written to the FIFO as {tuser, tlast, pixel}, with a write-to-m_axis_tvalid latency of 1 cycle.
REQ-032 If the FIFO is full on a pixel, that pixel SHALL be dropped, overflow SHALL be set, and x/y SHALL still advance so the frame geometry is preserved.
REQ-033 When the FIFO is full and the output is handshaking in the same cycle, the write SHALL succeed (no overflow).
REQ-034 vid_sof arriving in CAPTURE after the first pixel SHALL set sof_err; the pixel SHALL be treated as an ordinary pixel and SHALL not restart the counters.
REQ-035 vid_valid outside CAPTURE (other than the start pixel) SHALL be ignored.
REQ-036 DRAIN SHALL exit when the FIFO is empty. On exit: frame_done SHALL pulse for one cycle, frame_count SHALL increment, and the next state SHALL be IDLE if cfg_single=1 or cfg_enable=0, otherwise WAIT_SOF.
REQ-037 Deasserting cfg_enable during CAPTURE or DRAIN SHALL let the current frame complete.
REQ-038 m_axis_tvalid SHALL equal FIFO not-empty; m_axis_tdata, m_axis_tlast and m_axis_tuser SHALL be held stable while tvalid=1 and tready=0.
REQ-039 When cfg_clear coincides with a frame_done increment, the clear SHALL win; when cfg_clear coincides with an error event, the flag SHALL be set.

Reset
REQ-040 ARESET SHALL force, immediately and in any state, state=IDLE, FIFO empty, x=y=0 and all outputs 0 (tvalid, tlast, tuser, tdata, busy, frame_done, overflow, sof_err, frame_count); a partial frame in flight SHALL be discarded.

Structure
REQ-041 The package capture_pkg SHALL hold the state enum, the FIFO entry width (PIX_W+2) and the output data width (32).
REQ-042 The block SHALL contain one sub-module, capture_fifo: a synchronous FIFO with full/empty flags and simultaneous read/write support.

Verification
REQ-043 Scenario: hsize=4, vsize=2, enable=1, single=1, tready=1, SOF followed by 8 pixels 0x01..0x08 -> 8 beats; tuser on 0x01; tlast on 0x04 and 0x08; one frame_done pulse; frame_count=1; ends in IDLE.
REQ-044 Scenario: same frame with tready=0 for 10 cycles -> first 4 beats held; overflow=1; tlast still on the 4th/8th pixel slots; frame_done after drain.
REQ-045 Scenario: vid_sof on pixel 3 of line 0 -> sof_err=1; beat count unchanged (8).
REQ-046 Scenario: enable=1, single=0, two SOF frames -> frame_count=2; busy stays high between frames; WAIT_SOF after each.
REQ-047 Scenario: ARESET asserted mid-line with the FIFO holding 2 beats -> tvalid=0 and state IDLE in the same cycle; the next frame starts clean with tuser=1.
REQ-048 Scenario: cfg_hsize=0, cfg_vsize=0 -> a 1-pixel frame with tuser=1, tlast=1 and frame_done.
